// File: rtl/alert_handler_ping_pkg.sv
// Shared state encoding and LFSR constants for the escalation ping scheduler.
package alert_handler_ping_pkg;

  typedef enum logic [1:0] {
    Idle = 2'b00,
    Wait = 2'b01,
    Ping = 2'b10
  } ping_state_e;

  localparam logic [31:0] LFSR_POLY         = 32'h8000_0057;
  localparam logic [31:0] LFSR_SEED_DEFAULT = 32'h7FFF_FFFF;

  // Right-shifting Galois step: feedback tap taken from bit 0.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? LFSR_POLY : 32'h0);
  endfunction

endpackage

// File: rtl/alert_handler_ping_lfsr.sv
// 32-bit Galois LFSR supplying the pseudo-random ping spacing; holds while disabled.
module alert_handler_ping_lfsr
  import alert_handler_ping_pkg::*;
#(
  parameter logic [31:0] SEED = LFSR_SEED_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  output logic [31:0] state_o
);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   state_o <= SEED;
    else if (en_i) state_o <= lfsr_step(state_o);
  end

endmodule

// File: rtl/alert_handler_esc_ping_sched.sv
// Round-robin liveness pinger for the escalation senders, with LFSR-randomised spacing.
// Build option ALERT_HANDLER_PING_FAIL_STICKY_EN makes esc_ping_fail_o sticky until en_i drops.
module alert_handler_esc_ping_sched
  import alert_handler_ping_pkg::*;
#(
  parameter int unsigned N_ESC_SEV   = 4,
  parameter int unsigned PING_CNT_DW = 24,
  parameter logic [31:0] LFSR_SEED   = LFSR_SEED_DEFAULT,
  parameter int unsigned WAIT_DW     = 8,
  parameter int unsigned MIN_WAIT    = 16,
  localparam int unsigned IdW        = (N_ESC_SEV > 1) ? $clog2(N_ESC_SEV) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   en_i,
  input  logic [PING_CNT_DW-1:0] ping_timeout_cyc_i,
  input  logic [N_ESC_SEV-1:0]   esc_en_i,
  input  logic [N_ESC_SEV-1:0]   esc_active_i,
  input  logic [N_ESC_SEV-1:0]   ping_ok_i,
  output logic [N_ESC_SEV-1:0]   ping_req_o,
  output logic                   esc_ping_fail_o,
  output logic [1:0]             ping_state_o,
  output logic [IdW-1:0]         ping_id_o
);

  ping_state_e            state_q, state_d;
  logic [IdW-1:0]         ptr_q, ptr_d, ptr_inc;
  logic [PING_CNT_DW-1:0] wait_cnt_q, wait_cnt_d;
  logic [PING_CNT_DW-1:0] ping_cnt_q, ping_cnt_d;
  logic [N_ESC_SEV-1:0]   req_q, req_d;
  logic                   fail_q, fail_d;

  logic [31:0]            lfsr_q;
  logic [PING_CNT_DW:0]   wait_sum;
  logic [PING_CNT_DW-1:0] wait_load;
  logic                   unused_lfsr_hi;

  alert_handler_ping_lfsr #(
    .SEED(LFSR_SEED)
  ) u_lfsr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (en_i),
    .state_o(lfsr_q)
  );

  // Spacing comes from the current (pre-advance) LFSR value; sum saturates.
  assign wait_sum       = {1'b0, PING_CNT_DW'(lfsr_q[WAIT_DW-1:0])} + (PING_CNT_DW+1)'(MIN_WAIT);
  assign wait_load      = wait_sum[PING_CNT_DW] ? '1 : wait_sum[PING_CNT_DW-1:0];
  assign unused_lfsr_hi = ^lfsr_q[31:WAIT_DW];

  assign ptr_inc = (ptr_q == IdW'(N_ESC_SEV - 1)) ? '0 : ptr_q + IdW'(1);

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    wait_cnt_d = wait_cnt_q;
    ping_cnt_d = ping_cnt_q;
    req_d      = '0;
`ifdef ALERT_HANDLER_PING_FAIL_STICKY_EN
    fail_d     = fail_q;
`else
    fail_d     = 1'b0;
`endif
    if (!en_i) begin
      // Disable wins everywhere; pointer is kept so the rotation resumes in place.
      state_d    = Idle;
      wait_cnt_d = '0;
      ping_cnt_d = '0;
      fail_d     = 1'b0;
    end else begin
      unique case (state_q)
        Idle: begin
          wait_cnt_d = wait_load;
          state_d    = Wait;
        end
        Wait: begin
          if (wait_cnt_q == '0) begin
            if (esc_en_i[ptr_q]) begin
              state_d       = Ping;
              ping_cnt_d    = '0;
              req_d[ptr_q]  = 1'b1;
            end else begin
              ptr_d      = ptr_inc;
              wait_cnt_d = wait_load;
            end
          end else begin
            wait_cnt_d = wait_cnt_q - 1'b1;
          end
        end
        Ping: begin
          // An escalating sender cannot answer, so activity counts as a good ack.
          if (ping_ok_i[ptr_q] || esc_active_i[ptr_q] ||
              (ping_cnt_q >= ping_timeout_cyc_i)) begin
            if (!ping_ok_i[ptr_q] && !esc_active_i[ptr_q]) fail_d = 1'b1;
            ptr_d      = ptr_inc;
            wait_cnt_d = wait_load;
            ping_cnt_d = '0;
            state_d    = Wait;
          end else begin
            req_d[ptr_q] = 1'b1;
            if (ping_cnt_q != '1) ping_cnt_d = ping_cnt_q + 1'b1;
          end
        end
        default: state_d = Idle;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= Idle;
      ptr_q      <= '0;
      wait_cnt_q <= '0;
      ping_cnt_q <= '0;
      req_q      <= '0;
      fail_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      wait_cnt_q <= wait_cnt_d;
      ping_cnt_q <= ping_cnt_d;
      req_q      <= req_d;
      fail_q     <= fail_d;
    end
  end

  assign ping_req_o      = req_q;
  assign esc_ping_fail_o = fail_q;
  assign ping_state_o    = state_q;
  assign ping_id_o       = ptr_q;

endmodule

// File: tb/tb_alert_handler_esc_ping_sched.sv
// Directed bench for the escalation ping scheduler: rotation, timeout, masking, boundaries, reset.
module tb_alert_handler_esc_ping_sched;
  localparam int N    = 4;
  localparam int CW   = 24;
  localparam int MINW = 16;
`ifdef ALERT_HANDLER_PING_FAIL_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic [CW-1:0] tmo = '0;
  logic [N-1:0]  esc_en = '0, esc_act = '0, dly_mask = '0, imm_mask = '0;
  logic [N-1:0]  req;
  logic          fail;
  logic [1:0]    st;
  logic [1:0]    id;
  logic [2:0][N-1:0] ok_dly = '0;
  wire  [N-1:0]  ping_ok = (ok_dly[2] & dly_mask) | (req & imm_mask);

  int n_chk = 0, n_err = 0;
  int ids[$];
  int gaps[$];
  int fails, lat;

  always #5 clk = ~clk;
  // Responder: echoes the request three cycles later.
  always @(posedge clk) ok_dly <= {ok_dly[1:0], req};

  alert_handler_esc_ping_sched dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .en_i              (en),
    .ping_timeout_cyc_i(tmo),
    .esc_en_i          (esc_en),
    .esc_active_i      (esc_act),
    .ping_ok_i         (ping_ok),
    .ping_req_o        (req),
    .esc_ping_fail_o   (fail),
    .ping_state_o      (st),
    .ping_id_o         (id)
  );

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    en = 0; esc_en = '0; esc_act = '0; dly_mask = '0; imm_mask = '0; tmo = '0;
    rst_n = 0;
    step(2);
    rst_n = 1;
    step(1);
  endtask

  function automatic int onehot_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic wait_req(input string tag, input int budget);
    int c = 0;
    while (req == '0 && c < budget) begin step(1); c++; end
    chk(tag, req != '0, 1);
  endtask

  // Records request rises (id, preceding low-gap) and fail pulses, bounded by budget.
  task automatic collect(input string tag, input int n, input int budget);
    int low = 0, cyc = 0;
    logic [N-1:0] prev = req;
    ids.delete(); gaps.delete(); fails = 0; lat = -1;
    while (ids.size() < n && cyc < budget) begin
      step(1); cyc++;
      if (fail) fails++;
      if (req != '0 && prev == '0) begin
        if (lat < 0) lat = cyc; else gaps.push_back(low);
        ids.push_back(onehot_idx(req));
        chk({tag, "_onehot"}, $countones(req), 1);
        low = 0;
      end else if (req == '0) low++;
      prev = req;
    end
    chk({tag, "_count"}, ids.size(), n);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi, f, bad, fbad;
    logic [N-1:0] seen;

    // Reset state
    do_reset();
    chk("rst_state", st, 0);
    chk("rst_req", req, 0);
    chk("rst_fail", fail, 0);
    chk("rst_id", id, 0);

    // Round robin, echo ack after 3 cycles; first wait uses seed low byte 0xFF -> 271
    esc_en = 4'b1111; tmo = 10; dly_mask = 4'b1111; en = 1;
    collect("rr", 5, 2500);
    chk("rr_first_lat", lat, 273);
    for (int i = 0; i < ids.size(); i++) chk($sformatf("rr_id%0d", i), ids[i], i % 4);
    // Low cycles are the loaded wait plus the zero-compare cycle.
    foreach (gaps[i]) chk($sformatf("rr_gap%0d", i),
                          (gaps[i] - 1 >= MINW) && (gaps[i] - 1 <= MINW + 255), 1);
    chk("rr_fail", fails, 0);

    // Timeout: request held for timeout+1 cycles, then fail
    do_reset();
    esc_en = 4'b0010; tmo = 5; en = 1;
    wait_req("to_req", 2000);
    chk("to_req_val", req, 4'b0010);
    hi = 0; f = 0;
    while (req == 4'b0010 && hi < 50) begin hi++; f += fail; step(1); end
    chk("to_len", hi, 6);
    chk("to_fail_early", f, 0);
    chk("to_fail", fail, 1);
    chk("to_state", st, 1);
    chk("to_id", id, 2);
    step(1);
    chk("to_fail_next", fail, STICKY);
    step(5);
    chk("to_fail_later", fail, STICKY);
    en = 0;
    step(1);
    chk("to_fail_en0", fail, 0);

    // Skip and mask: ids 1,3 skipped; id 2 escalating counts as success
    do_reset();
    esc_en = 4'b0101; esc_act = 4'b0100; dly_mask = 4'b0001; tmo = 20; en = 1;
    collect("sk", 4, 4000);
    for (int i = 0; i < ids.size(); i++) chk($sformatf("sk_id%0d", i), ids[i], (i % 2) * 2);
    chk("sk_fail", fails, 0);

    // Zero timeout with same-cycle ok: ok wins
    do_reset();
    esc_en = 4'b1111; tmo = 0; imm_mask = 4'b1111; en = 1;
    collect("t0ok", 3, 2000);
    for (int i = 0; i < ids.size(); i++) chk($sformatf("t0ok_id%0d", i), ids[i], i);
    chk("t0ok_fail", fails, 0);

    // Zero timeout without ok: one request cycle then fail
    do_reset();
    esc_en = 4'b1111; tmo = 0; en = 1;
    wait_req("t0_req", 2000);
    hi = 0;
    while (req != '0 && hi < 50) begin hi++; step(1); end
    chk("t0_len", hi, 1);
    chk("t0_fail", fail, 1);
    chk("t0_id", id, 1);

    // esc_en drop mid-ping does not abort; en drop clears request, keeps ptr
    do_reset();
    esc_en = 4'b0010; tmo = 1000; en = 1;
    wait_req("dr_req", 2000);
    esc_en = '0;
    step(2);
    chk("dr_esc_drop_req", req, 4'b0010);
    en = 0;
    step(1);
    chk("dr_req_clr", req, 0);
    chk("dr_state", st, 0);
    chk("dr_fail", fail, 0);
    chk("dr_id", id, 1);
    step(3);
    chk("dr_fail_later", fail, 0);
    chk("dr_state_later", st, 0);

    // All senders disabled: rotation only, no requests or fails
    do_reset();
    en = 1;
    bad = 0; fbad = 0; seen = '0;
    for (int c = 0; c < 2000; c++) begin
      step(1);
      if (req != '0) bad++;
      if (fail) fbad++;
      seen[id] = 1'b1;
    end
    chk("off_req", bad, 0);
    chk("off_fail", fbad, 0);
    chk("off_ptr_rot", seen, 4'b1111);

    // Asynchronous reset mid-ping
    do_reset();
    esc_en = 4'b0100; tmo = 1000; en = 1;
    wait_req("ar_req", 2000);
    chk("ar_req_val", req, 4'b0100);
    #2;
    rst_n = 0;
    #1;
    chk("ar_req", req, 0);
    chk("ar_fail", fail, 0);
    chk("ar_state", st, 0);
    chk("ar_id", id, 0);
    en = 0;
    step(1);
    rst_n = 1;
    step(2);
    chk("ar_post_state", st, 0);
    chk("ar_post_id", id, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
